// File: rtl/light_serial_tx.sv
// light_serial_tx: FIFO-buffered serial pattern transmitter (start, 8 data bits LSB first, stop).
// Define LIGHT_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module light_serial_tx #(
    parameter int DIV   = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   wr_en,
    input  logic [7:0]             pdata,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   dout,
    output logic                   busy,
    output logic                   done
);

    localparam int          AW       = $clog2(DEPTH);
    localparam int          DIV_M1   = DIV - 1;
    localparam logic [7:0]  CNT_MAX  = DIV_M1[7:0];
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
    localparam logic [AW:0] PTR_ONE  = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [AW:0] w_count;
    logic [7:0]  w_head;
    logic        w_nonempty;
    logic        w_full;
    logic        w_wr;
    logic        w_pop;

    logic [7:0]  r_cnt;
    logic [2:0]  r_bit_idx;
    logic        w_tick;
    logic [7:0]  r_shift;
    logic        r_dout;
    logic        r_done;

    // Write handshake: wr_en is the request and full is the inverse of ready; a byte is
    // taken on any rising edge with wr_en=1 and full=0, and is simply dropped otherwise.
    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_nonempty = (r_wr_ptr != r_rd_ptr);
    assign w_full     = (w_count == FULL_LVL);
    assign w_wr       = wr_en && !w_full;
    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
    assign w_tick     = (r_cnt == CNT_MAX);

    // Pop exactly on the edges where the FSM enters START.
    assign w_pop = w_nonempty && ((r_state == IDLE) || ((r_state == STOP) && w_tick));

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= pdata;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_nonempty) begin
                    w_next_state = START;
                end
            end
            START: begin
                if (w_tick) begin
                    w_next_state = DATA;
                end
            end
            DATA: begin
                if (w_tick && (r_bit_idx == 3'd7)) begin
`ifdef LIGHT_TX_PARITY_EN
                    w_next_state = PARITY;
`else
                    w_next_state = STOP;
`endif
                end
            end
`ifdef LIGHT_TX_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_next_state = STOP;
                end
            end
`endif
            STOP: begin
                if (w_tick) begin
                    w_next_state = w_nonempty ? START : IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Bit-time counter restarts at every state boundary, so each state lasts DIV clocks.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
        end else begin
            if ((r_state == IDLE) || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
            if ((r_state == DATA) && w_tick) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_shift <= '0;
        end else if (w_pop) begin
            r_shift <= w_head;
        end else if ((r_state == DATA) && w_tick) begin
            r_shift <= {1'b0, r_shift[7:1]};
        end
    end

`ifdef LIGHT_TX_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^w_head;
        end
    end
`endif

    // Line and done are registered from the current state, so they trail the FSM by one clock.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_dout <= 1'b1;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == STOP) && w_tick;
            case (r_state)
                IDLE:    r_dout <= 1'b1;
                START:   r_dout <= 1'b0;
                DATA:    r_dout <= r_shift[0];
`ifdef LIGHT_TX_PARITY_EN
                PARITY:  r_dout <= r_parity;
`endif
                STOP:    r_dout <= 1'b1;
                default: r_dout <= 1'b1;
            endcase
        end
    end

    assign dout  = r_dout;
    assign done  = r_done;
    assign busy  = (r_state != IDLE);
    assign full  = w_full;
    assign count = w_count;

endmodule

// File: tb/tb_light_serial_tx.sv
// Bench for light_serial_tx: frame-position reference model, line decoder and scenario tasks.
`timescale 1ns/1ps
module tb_light_serial_tx;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
`ifdef LIGHT_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = (10 + PAR) * DIV;

    logic                   clk   = 1'b0;
    logic                   arst  = 1'b1;
    logic                   wr_en = 1'b0;
    logic [7:0]             pdata = 8'h00;
    logic                   full;
    logic [$clog2(DEPTH):0] count;
    logic                   dout;
    logic                   busy;
    logic                   done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    light_serial_tx #(.DIV(DIV), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .arst  (arst),
        .wr_en (wr_en),
        .pdata (pdata),
        .full  (full),
        .count (count),
        .dout  (dout),
        .busy  (busy),
        .done  (done)
    );

    // Reference model: queue of pending bytes plus clocks left in the frame in flight.
    logic [7:0] exp_q[$];
    logic [7:0] pop_log[$];
    logic [7:0] got_q[$];
    int         m_left = 0;
    logic [7:0] m_cur  = 8'h00;
    logic       m_dout = 1'b1;
    logic       m_done = 1'b0;
    int         m_sz, m_p, m_b;
    logic       m_acc;

    always @(posedge clk or negedge arst) begin
        if (!arst) begin
            exp_q.delete();
            m_left = 0;
            m_dout = 1'b1;
            m_done = 1'b0;
        end else begin
            m_sz  = exp_q.size();
            m_acc = wr_en && (m_sz < DEPTH);
            if (m_left == 0) begin
                m_dout = 1'b1;
            end else begin
                m_p = FL - m_left;
                m_b = m_p / DIV;
                if (m_b == 0)                  m_dout = 1'b0;
                else if (m_b <= 8)             m_dout = m_cur[m_b-1];
                else if (PAR == 1 && m_b == 9) m_dout = ^m_cur;
                else                           m_dout = 1'b1;
            end
            m_done = (m_left == 1);
            if (m_left > 1) begin
                m_left = m_left - 1;
            end else if (m_sz > 0) begin
                m_cur  = exp_q.pop_front();
                pop_log.push_back(m_cur);
                m_left = FL;
            end else begin
                m_left = 0;
            end
            if (m_acc) exp_q.push_back(pdata);
        end
    end

    // Line decoder: samples each data bit mid bit-time and collects complete frames.
    int         mon_pos = -1;
    logic [7:0] mon_byte = 8'h00;

    always @(negedge clk or negedge arst) begin
        if (!arst) begin
            mon_pos = -1;
        end else if (mon_pos < 0) begin
            if (dout == 1'b0) mon_pos = 0;
        end else begin
            mon_pos = mon_pos + 1;
            if ((mon_pos % DIV) == (DIV / 2) && (mon_pos / DIV) >= 1 && (mon_pos / DIV) <= 8)
                mon_byte[(mon_pos / DIV) - 1] = dout;
            if (mon_pos == FL - 1) begin
                got_q.push_back(mon_byte);
                mon_pos = -1;
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++; if (dout !== 1'b1) begin n_fail++; $display("FAIL reset_dout: got %b want 1", dout); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (count !== 0)   begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        arst = 1'b1;
    endtask

    task automatic test_idle();
        repeat (100) begin
            @(negedge clk);
            n_tests++;
            if (dout !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL idle: dout=%b busy=%b done=%b want 1/0/0", dout, busy, done);
            end
        end
    endtask

    task automatic test_frame(input logic [7:0] b, input logic [10:0] exp_bits, input string name);
        got_q.delete();
        @(negedge clk); wr_en = 1'b1; pdata = b;
        @(negedge clk); wr_en = 1'b0;
        n_tests++; if (count !== 1) begin n_fail++; $display("FAIL %s_wr_visible: count %0d want 1", name, count); end
        n_tests++; if (dout !== 1'b1) begin n_fail++; $display("FAIL %s_n1_dout: got %b want 1", name, dout); end
        @(negedge clk);
        n_tests++;
        if (dout !== 1'b1 || busy !== 1'b1 || count !== 0) begin
            n_fail++;
            $display("FAIL %s_start: dout=%b busy=%b count=%0d want 1/1/0", name, dout, busy, count);
        end
        @(negedge clk);
        for (int k = 0; k < FL; k++) begin
            if (k > 0) @(negedge clk);
            n_tests++;
            if (dout !== exp_bits[k / DIV]) begin
                n_fail++;
                $display("FAIL %s_bit: clock %0d dout %b want %b", name, k + 1, dout, exp_bits[k / DIV]);
            end
            n_tests++;
            if (done !== (k == FL - 1)) begin
                n_fail++;
                $display("FAIL %s_done: clock %0d done %b want %b", name, k + 1, done, (k == FL - 1));
            end
        end
        @(negedge clk);
        n_tests++;
        if (dout !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_end: dout=%b busy=%b done=%b want 1/0/0", name, dout, busy, done);
        end
        n_tests++;
        if (got_q.size() != 1 || got_q[0] !== b) begin
            n_fail++;
            $display("FAIL %s_decode: %0d frames, first %h want %h", name, got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 8'hxx, b);
        end
    endtask

    task automatic test_single_frame();
        logic [10:0] bits;
`ifdef LIGHT_TX_PARITY_EN
        bits = 11'b10010011010;
`else
        bits = 11'b01010011010;
`endif
        test_frame(8'b01001101, bits, "single");
    endtask

    task automatic test_parity();
        logic [10:0] bits;
`ifdef LIGHT_TX_PARITY_EN
        bits = 11'b11000000010;
`else
        bits = 11'b01000000010;
`endif
        test_frame(8'b00000001, bits, "parity");
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || m_left != 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            n_tests++;
            if (dout !== m_dout || busy !== (m_left != 0) || done !== m_done || count !== exp_q.size()) begin
                n_fail++;
                $display("FAIL %s_model: dout %b/%b busy %b/%b done %b/%b count %0d/%0d", name,
                         dout, m_dout, busy, (m_left != 0), done, m_done, count, exp_q.size());
            end
        end
        n_tests++;
        if (cyc >= 3000) begin n_fail++; $display("FAIL %s_timeout: %0d cycles", name, cyc); end
        @(negedge clk);
        #1;
    endtask

    task automatic test_overflow();
        logic [7:0] want[$];
        got_q.delete();
        @(negedge clk); wr_en = 1'b1; pdata = 8'h5A;
        @(negedge clk); wr_en = 1'b0;
        @(negedge clk);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ovf_busy: got %b want 1", busy); end
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; pdata = 8'(8'hA1 + i);
            @(negedge clk);
            n_tests++;
            if (count !== ((i < 4) ? i + 1 : 4)) begin
                n_fail++; $display("FAIL ovf_count: write %0d count %0d want %0d", i, count, (i < 4) ? i + 1 : 4);
            end
            n_tests++;
            if (full !== (i >= 3)) begin
                n_fail++; $display("FAIL ovf_full: write %0d full %b want %b", i, full, (i >= 3));
            end
        end
        wr_en = 1'b0;
        drain("ovf");
        want = '{8'h5A, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        n_tests++;
        if (got_q.size() != want.size()) begin
            n_fail++; $display("FAIL ovf_frames: got %0d frames want %0d", got_q.size(), want.size());
        end else begin
            foreach (want[i]) begin
                n_tests++;
                if (got_q[i] !== want[i]) begin
                    n_fail++; $display("FAIL ovf_byte: frame %0d got %h want %h", i, got_q[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_simul_write_pop();
        logic [7:0] x, y, z;
        int cyc;
        x = 8'($urandom); y = 8'($urandom); z = 8'($urandom);
        got_q.delete();
        @(negedge clk); wr_en = 1'b1; pdata = x;
        @(negedge clk); wr_en = 1'b0;
        @(negedge clk); wr_en = 1'b1; pdata = y;
        @(negedge clk); wr_en = 1'b0;
        n_tests++; if (count !== 1) begin n_fail++; $display("FAIL sim_pre_count: got %0d want 1", count); end
        cyc = 0;
        while (m_left != 1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++; if (cyc >= 200) begin n_fail++; $display("FAIL sim_wait: no stop end in %0d cycles", cyc); end
        wr_en = 1'b1; pdata = z;
        @(negedge clk); wr_en = 1'b0;
        n_tests++; if (count !== 1)   begin n_fail++; $display("FAIL sim_count: got %0d want 1", count); end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL sim_done: got %b want 1", done); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sim_busy: got %b want 1", busy); end
        drain("sim");
        n_tests++;
        if (got_q.size() != 3 || got_q[0] !== x || got_q[1] !== y || got_q[2] !== z) begin
            n_fail++;
            $display("FAIL sim_order: %0d frames, want %h %h %h", got_q.size(), x, y, z);
        end
    endtask

    task automatic test_reset_mid_frame();
        int cyc;
        got_q.delete();
        @(negedge clk); wr_en = 1'b1; pdata = 8'h96;
        @(negedge clk); pdata = 8'h3C;
        @(negedge clk); pdata = 8'hE7;
        @(negedge clk); wr_en = 1'b0;
        cyc = 0;
        while (mon_pos != 4 * DIV + 1 && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        n_tests++; if (cyc >= 200) begin n_fail++; $display("FAIL rst_wait: bit 3 not reached"); end
        #1 arst = 1'b0;
        #1;
        n_tests++;
        if (dout !== 1'b1 || busy !== 1'b0 || count !== 0 || full !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: dout=%b busy=%b count=%0d full=%b done=%b want 1/0/0/0/0",
                     dout, busy, count, full, done);
        end
        repeat (3) @(negedge clk);
        arst = 1'b1;
        repeat (50) begin
            @(negedge clk);
            n_tests++;
            if (dout !== 1'b1 || busy !== 1'b0 || count !== 0) begin
                n_fail++;
                $display("FAIL rst_after: dout=%b busy=%b count=%0d want 1/0/0", dout, busy, count);
            end
        end
        n_tests++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL rst_frames: got %0d want 0", got_q.size()); end
    endtask

    task automatic test_random();
        got_q.delete();
        pop_log.delete();
        repeat (400) begin
            @(negedge clk);
            n_tests++;
            if (dout !== m_dout || busy !== (m_left != 0) || done !== m_done ||
                count !== exp_q.size() || full !== (exp_q.size() == DEPTH)) begin
                n_fail++;
                $display("FAIL rand_model: dout %b/%b busy %b/%b done %b/%b count %0d/%0d full %b",
                         dout, m_dout, busy, (m_left != 0), done, m_done, count, exp_q.size(), full);
            end
            wr_en = ($urandom_range(0, 99) < 15);
            pdata = 8'($urandom);
        end
        wr_en = 1'b0;
        drain("rand");
        n_tests++;
        if (got_q.size() != pop_log.size()) begin
            n_fail++; $display("FAIL rand_frames: got %0d want %0d", got_q.size(), pop_log.size());
        end else begin
            foreach (pop_log[i]) begin
                n_tests++;
                if (got_q[i] !== pop_log[i]) begin
                    n_fail++; $display("FAIL rand_byte: frame %0d got %h want %h", i, got_q[i], pop_log[i]);
                end
            end
        end
    endtask

    initial begin
        #1 arst = 1'b0;
        test_reset();
        test_idle();
        test_single_frame();
        test_parity();
        test_overflow();
        test_simul_write_pop();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/light_serial_tx.md
LIGHT_SERIAL_TX -- requirements
Module: light_serial_tx

Interface
REQ-001 SHALL have parameter DIV, default 4: clocks per serial bit, legal range 2..255.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO entries, power of two, 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all flops rising-edge.
REQ-004 SHALL have port arst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 SHALL have port wr_en  input  1  request to enqueue pdata this cycle.
REQ-006 SHALL have port pdata  input  8  parallel pattern byte to transmit.
REQ-007 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-008 SHALL have port count  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-009 SHALL have port dout  output  1  serial line, registered, idle high.
REQ-010 SHALL have port busy  output  1  FSM not in IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse on the last clock of STOP.

Function
REQ-012 SHALL accept a write on a rising edge when wr_en=1 and full=0; the write is visible in count on the next cycle.
REQ-013 SHALL ignore wr_en when full=1, even if a pop occurs in the same cycle. The FIFO contents and count SHALL be unchanged in that case.
REQ-014 SHALL pop the FIFO head only on the IDLE->START or STOP->START transition. A simultaneous write and pop SHALL leave count unchanged.
REQ-015 SHALL wrap the read and write pointers modulo DEPTH. Pointer width SHALL be clog2(DEPTH)+1 so that full and empty are unambiguous.
REQ-016 SHALL implement the FSM states IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-017 SHALL transition from IDLE to START on the edge where count!=0.
REQ-018 SHALL transition from START to DATA, DATA to PARITY or STOP, and PARITY to STOP, each after DIV clocks.
REQ-019 SHALL leave STOP after DIV clocks: to START if count!=0 (back-to-back frames, no idle gap), otherwise to IDLE.
REQ-020 SHALL drive dout as follows: IDLE=1, START=0, DATA=data bits LSB first (bit i held DIV clocks, i=0..7), STOP=1.
REQ-021 SHALL use a bit-time counter that counts 0..DIV-1 and a 3-bit bit index; the index SHALL advance only at the counter terminal value.
REQ-022 SHALL give a write on edge N, with an empty FIFO and FSM in IDLE, the response dout=0 from edge N+2.
REQ-023 SHALL capture the popped byte into a shift register at the pop. Later FIFO writes SHALL NOT alter the frame in flight.
REQ-024 SHALL assert busy=1 in every state except IDLE.

Reset
REQ-025 SHALL, while arst=0, immediately force: state=IDLE, dout=1, busy=0, done=0, count=0, full=0, pointers=0, counters=0.
REQ-026 SHALL, on reset asserted mid-frame, abort the frame, discard all FIFO entries and return dout to 1 without waiting for a clock.
REQ-027 SHALL resume normal operation on the first rising edge after arst returns to 1.

Configuration
REQ-028 SHALL use the macro LIGHT_TX_PARITY_EN to control the PARITY state.
REQ-029 SHALL, when LIGHT_TX_PARITY_EN is defined, insert a PARITY state after DATA that drives the even-parity bit (XOR of the 8 data bits) for DIV clocks; frame = 11 bit-times.
REQ-030 SHALL, when LIGHT_TX_PARITY_EN is undefined, go directly from DATA to STOP; frame = 10 bit-times, and no parity logic SHALL be synthesized.

Verification
REQ-031 SHALL cover single frame: DIV=4, write 8'b01001101 after reset -> dout held 4 clocks each: 0,1,0,1,1,0,0,1,0,1; done pulses once at clock 40 of the frame.
REQ-032 SHALL cover parity: with LIGHT_TX_PARITY_EN, byte 8'b01001101 (four 1s) -> parity bit 0 before stop; byte 8'b00000001 -> parity bit 1.
REQ-033 SHALL cover overflow: with busy=1, write 8'hA1..8'hA5 on 5 consecutive cycles -> full=1 after the 4th accepted write, 8'hA5 dropped; A1..A4 (count 4 at fill) emitted back-to-back with no idle gap.
REQ-034 SHALL cover simultaneous write and pop: write on the STOP->START edge with count=1 -> count stays 1 and the new byte follows next.
REQ-035 SHALL cover reset mid-frame: drop arst during DATA bit 3 -> dout=1, busy=0, count=0 immediately, with no further frames after release.
REQ-036 SHALL cover idle: no writes for 100 clocks after reset -> dout=1, busy=0, done=0 throughout.
